gp_reg_file: RTL and testbench

// - Parametrised general-purpose register file for the ALU datapath: 2 async read ports (A, B) and 1 sync write port (C).
// - Adds write-to-read bypass, a per-entry pending scoreboard for in-flight results, and a multi-cycle sweep flush FSM.
// - Sits between decode (addresses, reservations) and the ALU (operands, writeback).

---
 rtl/gp_reg_file_if.sv | 34 +++
 rtl/gp_reg_file.sv | 109 ++++++++++
 tb/tb_gp_reg_file.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/gp_reg_file_if.sv
// Bus bundle for gp_reg_file: read ports A/B, write port C, reservation and flush control.
interface gp_reg_file_if #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 16
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW-1:0]    a_addr;
    logic [WIDTH-1:0] a_data;
    logic             a_ready;
    logic [AW-1:0]    b_addr;
    logic [WIDTH-1:0] b_data;
    logic             b_ready;
    logic [AW-1:0]    c_addr;
    logic [WIDTH-1:0] c_data;
    logic             load;
    logic             load_ready;
    logic             rsv;
    logic [AW-1:0]    rsv_addr;
    logic             flush;
    logic             busy;

    // Decode/ALU side
    modport master (
        output a_addr, b_addr, c_addr, c_data, load, rsv, rsv_addr, flush,
        input  a_data, a_ready, b_data, b_ready, load_ready, busy
    );

    // Register file side
    modport slave (
        input  a_addr, b_addr, c_addr, c_data, load, rsv, rsv_addr, flush,
        output a_data, a_ready, b_data, b_ready, load_ready, busy
    );
endinterface

// File: rtl/gp_reg_file.sv
// General-purpose register file: 2 async read ports with write bypass, 1 sync write port,
// per-entry pending scoreboard and a DEPTH-cycle sweep flush.
// Optional feature macro: GP_REG_ZERO_EN (entry 0 hardwired to zero).
module gp_reg_file #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 16
) (
    input  logic          clk,
    input  logic          clear,
    gp_reg_file_if.slave  bus
);
    localparam int unsigned AW = $clog2(DEPTH);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SWEEP = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [AW-1:0]    ptr_q, ptr_d;
    logic [WIDTH-1:0] regs_q [DEPTH];
    logic [WIDTH-1:0] regs_d [DEPTH];
    logic [DEPTH-1:0] pend_q, pend_d;

    logic wr_acc;
    logic a_byp, b_byp;
    logic a_zero, b_zero, c_zero, r_zero;

    // Entry-0 hardwiring flags per address
`ifdef GP_REG_ZERO_EN
    assign a_zero = (bus.a_addr == '0);
    assign b_zero = (bus.b_addr == '0);
    assign c_zero = (bus.c_addr == '0);
    assign r_zero = (bus.rsv_addr == '0);
`else
    assign a_zero = 1'b0;
    assign b_zero = 1'b0;
    assign c_zero = 1'b0;
    assign r_zero = 1'b0;
`endif

    // Handshake status straight from the FSM state
    assign bus.load_ready = (state_q == ST_IDLE);
    assign bus.busy       = (state_q == ST_SWEEP);
    assign wr_acc         = bus.load & bus.load_ready;

    // Zero-latency write-to-read bypass; discarded writes to entry 0 are not forwarded
    assign a_byp = wr_acc && !c_zero && (bus.c_addr == bus.a_addr);
    assign b_byp = wr_acc && !c_zero && (bus.c_addr == bus.b_addr);

    // Read ports
    assign bus.a_data  = a_zero ? '0 : (a_byp ? bus.c_data : regs_q[bus.a_addr]);
    assign bus.b_data  = b_zero ? '0 : (b_byp ? bus.c_data : regs_q[bus.b_addr]);
    assign bus.a_ready = a_zero | ~pend_q[bus.a_addr] | a_byp;
    assign bus.b_ready = b_zero | ~pend_q[bus.b_addr] | b_byp;

    // Next-state: writes/reservations in IDLE, one entry cleared per cycle in SWEEP
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        regs_d  = regs_q;
        pend_d  = pend_q;

        unique case (state_q)
            ST_IDLE: begin
                if (wr_acc && !c_zero) begin
                    regs_d[bus.c_addr] = bus.c_data;
                    pend_d[bus.c_addr] = 1'b0;
                end
                // Applied after the write so a same-cycle new producer leaves the entry pending
                if (bus.rsv && !r_zero) begin
                    pend_d[bus.rsv_addr] = 1'b1;
                end
                if (bus.flush) begin
                    state_d = ST_SWEEP;
                    ptr_d   = '0;
                end
            end
            ST_SWEEP: begin
                regs_d[ptr_q] = '0;
                pend_d[ptr_q] = 1'b0;
                ptr_d         = ptr_q + AW'(1);
                if (ptr_q == AW'(DEPTH - 1)) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers with synchronous active-low clear
    always_ff @(posedge clk) begin
        if (!clear) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            pend_q  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            pend_q  <= pend_d;
            regs_q  <= regs_d;
        end
    end
endmodule

// File: tb/tb_gp_reg_file.sv
// Scoreboard bench for gp_reg_file: directed scenarios then random traffic vs a behavioural model.
module tb_gp_reg_file;
    localparam int unsigned WIDTH = 16;
    localparam int unsigned DEPTH = 16;

`ifdef GP_REG_ZERO_EN
    localparam bit ZEN = 1'b1;
`else
    localparam bit ZEN = 1'b0;
`endif

    typedef struct packed {
        logic        clr;
        logic        load;
        logic [3:0]  ca;
        logic [15:0] cd;
        logic [3:0]  aa;
        logic [3:0]  bb;
        logic        rsv;
        logic [3:0]  ra;
        logic        flush;
    } stim_t;

    typedef struct packed {
        logic [15:0] ad;
        logic        ar;
        logic [15:0] bd;
        logic        br;
        logic        busy;
        logic        lr;
    } obs_t;

    logic clk;
    logic clear;

    gp_reg_file_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    gp_reg_file #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .clear (clear),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   total = 0;
    int   bad   = 0;
    obs_t exp_q[$];

    // Reference model state
    logic [15:0] mem [16];
    bit          pend [16];
    bit          sweeping;
    int          swept;
    bit          mv = 1'b0;

    function automatic bit is_zero(input logic [3:0] a);
        return ZEN && (a == 4'd0);
    endfunction

    function automatic obs_t expect_of(input stim_t s);
        obs_t o;
        bit   wr;
        wr     = s.load && !sweeping && !is_zero(s.ca);
        o.busy = sweeping;
        o.lr   = !sweeping;
        if (is_zero(s.aa)) begin
            o.ad = 16'h0; o.ar = 1'b1;
        end else if (wr && s.ca == s.aa) begin
            o.ad = s.cd;  o.ar = 1'b1;
        end else begin
            o.ad = mem[s.aa]; o.ar = !pend[s.aa];
        end
        if (is_zero(s.bb)) begin
            o.bd = 16'h0; o.br = 1'b1;
        end else if (wr && s.ca == s.bb) begin
            o.bd = s.cd;  o.br = 1'b1;
        end else begin
            o.bd = mem[s.bb]; o.br = !pend[s.bb];
        end
        return o;
    endfunction

    // Effect of one clock edge on the model
    task automatic model_edge(input stim_t s);
        if (!s.clr) begin
            for (int i = 0; i < 16; i++) begin
                mem[i] = 16'h0; pend[i] = 1'b0;
            end
            sweeping = 1'b0;
            swept    = 0;
            mv       = 1'b1;
        end else if (sweeping) begin
            mem[swept]  = 16'h0;
            pend[swept] = 1'b0;
            swept++;
            if (swept == 16) begin
                sweeping = 1'b0;
                swept    = 0;
            end
        end else begin
            if (s.load && !is_zero(s.ca)) begin
                mem[s.ca] = s.cd; pend[s.ca] = 1'b0;
            end
            if (s.rsv && !is_zero(s.ra)) pend[s.ra] = 1'b1;
            if (s.flush) begin
                sweeping = 1'b1;
                swept    = 0;
            end
        end
    endtask

    task automatic drive(input stim_t s);
        clear        = s.clr;
        bus.load     = s.load;
        bus.c_addr   = s.ca;
        bus.c_data   = s.cd;
        bus.a_addr   = s.aa;
        bus.b_addr   = s.bb;
        bus.rsv      = s.rsv;
        bus.rsv_addr = s.ra;
        bus.flush    = s.flush;
    endtask

    // One cycle: drive inputs after the edge, queue the expected outputs, advance the model
    task automatic step(input stim_t s);
        @(posedge clk);
        #1;
        drive(s);
        if (mv) exp_q.push_back(expect_of(s));
        model_edge(s);
    endtask

    function automatic stim_t idle(input logic [3:0] aa, input logic [3:0] bb);
        stim_t s;
        s       = '0;
        s.clr   = 1'b1;
        s.aa    = aa;
        s.bb    = bb;
        return s;
    endfunction

    // Monitor: compare the DUT outputs against the oldest queued expectation
    always @(negedge clk) begin
        obs_t e, a;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = '{ad: bus.a_data, ar: bus.a_ready, bd: bus.b_data, br: bus.b_ready,
                  busy: bus.busy, lr: bus.load_ready};
            total++;
            if (a !== e) begin
                bad++;
                $display("FAIL outputs t=%0t a_addr=%0d b_addr=%0d got ad=%h ar=%b bd=%h br=%b busy=%b lr=%b want ad=%h ar=%b bd=%h br=%b busy=%b lr=%b",
                         $time, bus.a_addr, bus.b_addr, a.ad, a.ar, a.bd, a.br, a.busy, a.lr,
                         e.ad, e.ar, e.bd, e.br, e.busy, e.lr);
            end
        end
    end

    initial begin
        stim_t s;
        s = idle(4'd0, 4'd0);
        s.clr = 1'b0;
        drive(s);

        // Reset then sweep read addresses
        step(s);
        for (int i = 0; i < 16; i++) step(idle(4'(i), 4'(15 - i)));

        // Write with same-cycle bypass, then registered read
        s = idle(4'd5, 4'd5); s.load = 1'b1; s.ca = 4'd5; s.cd = 16'h1234;
        step(s);
        step(idle(4'd5, 4'd0));

        // Reservation blocks readiness until the result is written
        s = idle(4'd3, 4'd3); s.rsv = 1'b1; s.ra = 4'd3;
        step(s);
        step(idle(4'd3, 4'd5));
        s = idle(4'd3, 4'd3); s.load = 1'b1; s.ca = 4'd3; s.cd = 16'h00AA;
        step(s);
        step(idle(4'd3, 4'd3));

        // Same-cycle reservation and write: new producer wins
        s = idle(4'd7, 4'd7); s.load = 1'b1; s.ca = 4'd7; s.cd = 16'hBEEF; s.rsv = 1'b1; s.ra = 4'd7;
        step(s);
        step(idle(4'd7, 4'd7));

        // Fill with all-ones, flush with a same-cycle write, load during sweep
        for (int i = 0; i < 16; i++) begin
            s = idle(4'(i), 4'd0); s.load = 1'b1; s.ca = 4'(i); s.cd = 16'hFFFF;
            if (i == 9) begin s.rsv = 1'b1; s.ra = 4'd9; end
            step(s);
        end
        s = idle(4'd2, 4'd2); s.load = 1'b1; s.ca = 4'd2; s.cd = 16'h0F0F; s.flush = 1'b1;
        step(s);
        for (int i = 0; i < 16; i++) begin
            s = idle(4'(i), 4'(15 - i));
            s.load = 1'b1; s.ca = 4'(15 - i); s.cd = 16'h1111; s.rsv = 1'b1; s.ra = 4'(i);
            s.flush = (i == 4);
            step(s);
        end
        for (int i = 0; i < 16; i++) step(idle(4'(i), 4'(15 - i)));

        // Clear in the middle of a sweep, then a fresh full sweep
        for (int i = 0; i < 16; i++) begin
            s = idle(4'(i), 4'd0); s.load = 1'b1; s.ca = 4'(i); s.cd = 16'(16'hA000 + i);
            step(s);
        end
        s = idle(4'd0, 4'd0); s.flush = 1'b1;
        step(s);
        for (int i = 0; i < 6; i++) step(idle(4'(i), 4'(i + 6)));
        s = idle(4'd8, 4'd9); s.clr = 1'b0;
        step(s);
        for (int i = 0; i < 16; i++) step(idle(4'(i), 4'(15 - i)));
        s = idle(4'd1, 4'd1); s.flush = 1'b1;
        step(s);
        for (int i = 0; i < 18; i++) step(idle(4'(i), 4'(i)));

        // Entry 0 behaviour
        s = idle(4'd0, 4'd0); s.load = 1'b1; s.ca = 4'd0; s.cd = 16'h5555; s.rsv = 1'b1; s.ra = 4'd0;
        step(s);
        step(idle(4'd0, 4'd0));

        // Random traffic
        for (int n = 0; n < 1500; n++) begin
            s       = '0;
            s.clr   = ($urandom_range(0, 199) != 0);
            s.load  = 1'($urandom_range(0, 1));
            s.ca    = 4'($urandom);
            s.cd    = 16'($urandom);
            s.aa    = ($urandom_range(0, 2) == 0) ? s.ca : 4'($urandom);
            s.bb    = ($urandom_range(0, 2) == 0) ? s.ca : 4'($urandom);
            s.rsv   = ($urandom_range(0, 3) == 0);
            s.ra    = ($urandom_range(0, 3) == 0) ? s.ca : 4'($urandom);
            s.flush = ($urandom_range(0, 59) == 0);
            step(s);
        end
        step(idle(4'd0, 4'd0));

        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain left=%0d want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
